instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
- Fetch stage directly upstream of the instruction decoder.
- Owns the PC and issues word reads to instruction memory, with one request outstanding at a time.
- Buffers returned words in a small prefetch queue and presents them to decode over a valid/ready handshake.
- Handles branch redirects from execute (flush) and stops fetching once a HALT word has been fetched.

Parameters:
- ADDR_W, 16, PC / instruction-memory word-address width.
- FIFO_DEPTH, 2, prefetch queue entries; power of two, minimum 2.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  read request, held until accepted.
- imem_gnt  in  1  memory accepts the request in this cycle.
- imem_addr  out  ADDR_W  word address; stable while imem_req=1.
- imem_rvalid  in  1  read data valid; arrives at least 1 cycle after grant.
- imem_rdata  in  32  fetched instruction word.
- Instruction  out  32  head of queue to decode.
- instr_pc  out  ADDR_W  address of Instruction.
- instr_valid  out  1  Instruction/instr_pc valid.
- id_ready  in  1  decode consumes the head when instr_valid & id_ready.
- redirect  in  1  branch taken / flush (from execute).
- redirect_pc  in  ADDR_W  new fetch address.
- halted  out  1  HALT fetched and fetching stopped.

Behaviour:
Reset values:
- PC=RESET_PC; queue empty; imem_req=0; instr_valid=0; Instruction=0; instr_pc=0; halted=0; state IDLE.
- Reset asserted mid-transaction abandons everything.
- Any imem_rvalid arriving after reset release without a post-reset grant is ignored via the drop flag, which is cleared at reset.

State machine IDLE / REQ / WAIT / HALT:
- IDLE -> REQ when the queue has a free slot, counting the pending response as occupying a slot.
- REQ: imem_req=1, imem_addr=PC. On imem_gnt go to WAIT and PC <= PC+1, wrapping modulo 2^ADDR_W.
- WAIT: on imem_rvalid, push {imem_rdata, issued address} into the queue. Go to REQ if space remains, else IDLE.
- HALT word: imem_rdata[31:30]=2'b11 and [28:25]=4'b1000. It is pushed like any other word, then the FSM goes to HALT, asserts halted and issues no further requests.
- HALT exits only on redirect or reset.

Queue:
- Occupancy must never exceed FIFO_DEPTH. Issue is suppressed when occupancy + outstanding = FIFO_DEPTH.
- Simultaneous push and pop when full is legal; occupancy is unchanged.
- Head outputs are registered from queue storage; no combinational path from imem_rdata to Instruction.
- Pop happens only on instr_valid & id_ready. Instruction is held stable while instr_valid=1 and id_ready=0.

Redirect (highest priority):
- Same edge: queue cleared, PC <= redirect_pc, halted <= 0, instr_valid=0 the next cycle.
- In REQ without grant: address switches to redirect_pc the next cycle. An asserted request may retarget only on redirect.
- In REQ with grant in the same cycle: the granted request is treated as outstanding and stale, so drop is set.
- In WAIT: drop flag set; the next imem_rvalid is discarded, then fetch resumes at redirect_pc.
- Redirect coinciding with imem_rvalid discards that word.
- A pop in the redirect cycle is still honoured for the head it sees.

Latency:
- Redirect to first imem_req at redirect_pc is 1 cycle.
- rvalid to instr_valid is 1 cycle when the queue was empty.

Optional Feature:
- Macro: PREDECODE_BRANCH_EN.
- When defined, a pushed word with [31:25]=7'b1100000 (unconditional B) redirects the fetch PC internally to push_addr + sign_extend(word[15:0]) truncated to ADDR_W.
  - Only requests not yet granted are retargeted.
  - If one was granted, its response is dropped.
  - The branch word itself is still delivered to decode.
  - External redirect in the same cycle wins.
- When undefined, branch words are treated as ordinary words and sequential fetch continues.

Decomposition:
- Shared package fetch_pkg:
  - fetch state enum.
  - HALT and B-unconditional opcode constants, also used by decode.
  - ADDR_W default.
  - Instruction-field position constants.
- One natural sub-module: fetch_fifo, a synchronous FIFO with flush, parameterised on width and depth, holding {instr, pc}.

Test Plan:
- Sequential fetch, memory latency 1, id_ready=1, words 0x00400005 at addrs 0..3: instr_pc 0,1,2,3 on consecutive valid cycles; first instr_valid 3 cycles after reset release.
- id_ready=0 for 10 cycles, FIFO_DEPTH=2: exactly 2 grants issued, imem_req stays low, Instruction held at the addr-0 word; resumes on id_ready=1.
- Redirect to 0x0040 while in WAIT for addr 5: the addr-5 rvalid is discarded; next imem_addr=0x0040; no instr_pc=5 ever delivered.
- HALT 0xD0000000 at addr 3: delivered with instr_pc=3, halted=1, no imem_req after it; redirect to 0 clears halted and refetches from 0.
- rst_n pulsed low during WAIT: outputs at reset values asynchronously; a late rvalid is ignored; fetch restarts at RESET_PC.
- With PREDECODE_BRANCH_EN, B word 0xC000FFFC at addr 8: the next delivered instr_pc is 4; without the macro it is 9.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: types and constants shared by the fetch stage and decode.
//   - fetch_state_e : fetch FSM states
//   - HALT / unconditional-B opcode masks and match values
//   - instruction field positions (opcode, 16-bit immediate)
//   - ADDR_W_DEFAULT: default PC / instruction-memory word-address width
//   - is_halt / is_b_uncond: opcode classifiers on a full 32-bit word
package fetch_pkg;

    localparam int ADDR_W_DEFAULT = 16;

    // Instruction field positions
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 25;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;

    // HALT: [31:30]=2'b11, [28:25]=4'b1000, bit 29 is don't-care
    localparam logic [31:0] HALT_MASK  = 32'hDE00_0000;
    localparam logic [31:0] HALT_MATCH = 32'hD000_0000;

    // Unconditional branch: [31:25]=7'b1100000
    localparam logic [31:0] B_UNCOND_MASK  = 32'hFE00_0000;
    localparam logic [31:0] B_UNCOND_MATCH = 32'hC000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HALT = 2'd3
    } fetch_state_e;

    function automatic logic is_halt(input logic [31:0] word);
        return (word & HALT_MASK) == HALT_MATCH;
    endfunction

    function automatic logic is_b_uncond(input logic [31:0] word);
        return (word & B_UNCOND_MASK) == B_UNCOND_MATCH;
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: instruction-memory read bus.
//   imem_req    master->slave  read request, held until granted
//   imem_addr   master->slave  word address, stable while imem_req=1
//   imem_gnt    slave->master  request accepted this cycle
//   imem_rvalid slave->master  read data valid (>=1 cycle after grant)
//   imem_rdata  slave->master  32-bit instruction word
// The fetch stage is the master, the memory is the slave.
interface instruction_fetch_if #(
    parameter int ADDR_W = 16
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_gnt;
    logic              imem_rvalid;
    logic [31:0]       imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with flush holding {instr, pc} entries.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : empties the queue (wins over push)
//   push, din  : write an entry; accepted when not full or when popping
//   pop        : remove the head (ignored when empty)
//   dout       : head entry, zero while empty; driven from storage flops only
//   valid      : queue not empty
//   count      : current occupancy
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;

    logic empty;
    logic full;
    logic pop_ok;
    logic push_ok;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (PTR_W+1)'(DEPTH));
    assign pop_ok  = pop && !empty;
    // A push into a full queue is legal only when the head leaves the same cycle.
    assign push_ok = push && !flush && (!full || pop_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
                2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage carries no reset; empty entries are masked at the output.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_reg] <= din;
    end

    assign dout  = empty ? '0 : mem[rd_ptr_reg];
    assign valid = !empty;
    assign count = count_reg;

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: fetch stage feeding the instruction decoder.
//   clk, rst_n   : clock, asynchronous active-low reset
//   imem         : instruction-memory read bus (master side), one request
//                  outstanding at a time
//   Instruction  : head-of-queue word to decode
//   instr_pc     : word address of Instruction
//   instr_valid  : Instruction/instr_pc valid
//   id_ready     : decode takes the head when instr_valid & id_ready
//   redirect     : flush and refetch from redirect_pc (highest priority)
//   redirect_pc  : new fetch address
//   halted       : a HALT word was fetched and fetching has stopped
// Optional macro PREDECODE_BRANCH_EN: a pushed unconditional B word
// retargets the fetch PC to its own address + sign-extended imm16.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int                ADDR_W     = ADDR_W_DEFAULT,
    parameter int                FIFO_DEPTH = 2,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    instruction_fetch_if.master imem,
    output logic [31:0]         Instruction,
    output logic [ADDR_W-1:0]   instr_pc,
    output logic                instr_valid,
    input  logic                id_ready,
    input  logic                redirect,
    input  logic [ADDR_W-1:0]   redirect_pc,
    output logic                halted
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e      state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [ADDR_W-1:0] issued_reg, issued_next;   // address of the outstanding request
    logic              drop_reg, drop_next;       // next rvalid belongs to a stale request

    logic              req;
    logic              push;
    logic              pop;
    logic              room_after_push;
    logic [CNT_W-1:0]  fifo_count;

    assign pop = instr_valid && id_ready;

    // After this push, is there still a slot for one more outstanding request?
    assign room_after_push = (fifo_count < CNT_W'(FIFO_DEPTH - 1)) || pop;

    fetch_fifo #(
        .WIDTH (32 + ADDR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect),
        .push  (push),
        .din   ({imem.imem_rdata, issued_reg}),
        .pop   (pop),
        .dout  ({Instruction, instr_pc}),
        .valid (instr_valid),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            pc_reg     <= RESET_PC;
            issued_reg <= '0;
            drop_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            pc_reg     <= pc_next;
            issued_reg <= issued_next;
            drop_reg   <= drop_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        pc_next     = pc_reg;
        issued_next = issued_reg;
        drop_next   = drop_reg;
        req         = 1'b0;
        push        = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (fifo_count < CNT_W'(FIFO_DEPTH)) state_next = ST_REQ;
            end
            ST_REQ: begin
                req = 1'b1;
                if (imem.imem_gnt) begin
                    state_next  = ST_WAIT;
                    pc_next     = pc_reg + ADDR_W'(1);
                    issued_next = pc_reg;
                end
            end
            ST_WAIT: begin
                if (imem.imem_rvalid) begin
                    if (drop_reg) begin
                        drop_next  = 1'b0;
                        state_next = (fifo_count < CNT_W'(FIFO_DEPTH)) ? ST_REQ : ST_IDLE;
                    end else begin
                        push = 1'b1;
                        if (is_halt(imem.imem_rdata))
                            state_next = ST_HALT;
                        else if (room_after_push)
                            state_next = ST_REQ;
                        else
                            state_next = ST_IDLE;
`ifdef PREDECODE_BRANCH_EN
                        // Nothing else is in flight here, so only the PC moves.
                        if (is_b_uncond(imem.imem_rdata))
                            pc_next = issued_reg +
                                      ADDR_W'(signed'(imem.imem_rdata[IMM_MSB:IMM_LSB]));
`endif
                    end
                end
            end
            default: ;  // ST_HALT holds until redirect or reset
        endcase

        // Redirect overrides everything above; the queue is flushed by the FIFO.
        if (redirect) begin
            pc_next    = redirect_pc;
            push       = 1'b0;
            state_next = ST_REQ;
            drop_next  = 1'b0;
            if (state_reg == ST_REQ && imem.imem_gnt) begin
                // The request just granted is now stale; swallow its response.
                state_next = ST_WAIT;
                drop_next  = 1'b1;
            end else if (state_reg == ST_WAIT && !imem.imem_rvalid) begin
                state_next = ST_WAIT;
                drop_next  = 1'b1;
            end
        end
    end

    assign imem.imem_req  = req;
    assign imem.imem_addr = pc_reg;
    assign halted         = (state_reg == ST_HALT);

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;
    localparam int ADDR_W = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [31:0]       Instruction;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              id_ready = 1'b1;
    logic              redirect = 1'b0;
    logic [ADDR_W-1:0] redirect_pc = '0;
    logic              halted;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    instruction_fetch_if #(.ADDR_W(ADDR_W)) imem_bus ();

    instruction_fetch #(
        .ADDR_W     (ADDR_W),
        .FIFO_DEPTH (2),
        .RESET_PC   (16'h0000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem        (imem_bus),
        .Instruction (Instruction),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .id_ready    (id_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halted      (halted)
    );

    // ---------------- instruction memory model ----------------
    logic [31:0] mem_words [256];
    int          lat = 1;          // cycles from grant edge to rvalid
    logic        gnt_en = 1'b1;
    int          rv_cnt = 0;
    logic [31:0] rv_data = '0;

    assign imem_bus.imem_gnt    = imem_bus.imem_req && gnt_en;
    assign imem_bus.imem_rvalid = (rv_cnt == 1);
    assign imem_bus.imem_rdata  = (rv_cnt == 1) ? rv_data : 32'hDEAD_BEEF;

    // Not reset: a response in flight survives a DUT reset, like a real memory.
    always @(posedge clk) begin
        if (imem_bus.imem_req && imem_bus.imem_gnt) begin
            rv_cnt  <= lat;
            rv_data <= mem_words[imem_bus.imem_addr[7:0]];
        end else if (rv_cnt != 0) begin
            rv_cnt <= rv_cnt - 1;
        end
    end

    // ---------------- transaction monitor ----------------
    int          grant_cnt = 0;
    logic [15:0] gnt_addrs [$];
    logic [15:0] deliv_pc [$];
    logic [31:0] deliv_word [$];

    always @(negedge clk) begin
        #1;
        if (imem_bus.imem_req && imem_bus.imem_gnt) begin
            grant_cnt++;
            gnt_addrs.push_back(imem_bus.imem_addr);
        end
        if (instr_valid && id_ready) begin
            deliv_pc.push_back(instr_pc);
            deliv_word.push_back(Instruction);
            $display("[TB] deliver pc=%04h instr=%08h", instr_pc, Instruction);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers (stimulus only) ----------------
    task automatic fill_mem();
        for (int i = 0; i < 256; i++) mem_words[i] = 32'h0100_0000 + i;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        redirect = 1'b0;
        id_ready = 1'b1;
        gnt_en   = 1'b1;
        lat      = 1;
        repeat (6) @(negedge clk);
        grant_cnt = 0;
        gnt_addrs.delete();
        deliv_pc.delete();
        deliv_word.delete();
        rst_n = 1'b1;
    endtask

    task automatic wait_deliv(input int n, input int max_cycles);
        for (int i = 0; i < max_cycles && deliv_pc.size() < n; i++) @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        tests++; if (imem_bus.imem_req !== 1'b0) begin fails++; $display("FAIL reset_req: got %b want 0", imem_bus.imem_req); end
        tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
        tests++; if (Instruction !== 32'h0) begin fails++; $display("FAIL reset_instr: got %h want 0", Instruction); end
        tests++; if (instr_pc !== 16'h0) begin fails++; $display("FAIL reset_pc: got %h want 0", instr_pc); end
        tests++; if (halted !== 1'b0) begin fails++; $display("FAIL reset_halted: got %b want 0", halted); end
    endtask

    task automatic test_sequential();
        int first;
        fill_mem();
        for (int i = 0; i < 16; i++) mem_words[i] = 32'h0040_0005;
        apply_reset();
        first = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (instr_valid && first < 0) first = k;
        end
        tests++; if (first != 3) begin fails++; $display("FAIL seq_first_valid: got cycle %0d want 3", first); end
        tests++;
        if (deliv_pc.size() < 4) begin
            fails++; $display("FAIL seq_count: got %0d deliveries want >=4", deliv_pc.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                tests++;
                if (deliv_pc[k] !== 16'(k)) begin fails++; $display("FAIL seq_pc%0d: got %h want %h", k, deliv_pc[k], 16'(k)); end
            end
            tests++;
            if (deliv_word[0] !== 32'h0040_0005) begin fails++; $display("FAIL seq_word: got %h want 00400005", deliv_word[0]); end
        end
    endtask

    task automatic test_backpressure();
        int req_high;
        fill_mem();
        apply_reset();
        id_ready = 1'b0;
        req_high = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k > 6 && imem_bus.imem_req) req_high++;
        end
        tests++; if (grant_cnt != 2) begin fails++; $display("FAIL bp_grants: got %0d want 2", grant_cnt); end
        tests++; if (req_high != 0) begin fails++; $display("FAIL bp_req_low: got %0d req cycles want 0", req_high); end
        tests++; if (instr_valid !== 1'b1) begin fails++; $display("FAIL bp_valid: got %b want 1", instr_valid); end
        tests++; if (instr_pc !== 16'h0) begin fails++; $display("FAIL bp_hold_pc: got %h want 0", instr_pc); end
        tests++; if (Instruction !== 32'h0100_0000) begin fails++; $display("FAIL bp_hold_instr: got %h want 01000000", Instruction); end
        id_ready = 1'b1;
        wait_deliv(3, 30);
        tests++;
        if (deliv_pc.size() < 3) begin
            fails++; $display("FAIL bp_resume: got %0d deliveries want 3", deliv_pc.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                tests++;
                if (deliv_pc[k] !== 16'(k)) begin fails++; $display("FAIL bp_pc%0d: got %h want %h", k, deliv_pc[k], 16'(k)); end
            end
        end
    endtask

    task automatic test_redirect_wait();
        bit found;
        bit saw5;
        int dsz;
        int idx5;
        fill_mem();
        apply_reset();
        lat = 3;
        found = 0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(negedge clk);
            if (imem_bus.imem_req && imem_bus.imem_gnt && imem_bus.imem_addr == 16'h5) found = 1;
        end
        tests++; if (!found) begin fails++; $display("FAIL rdw_grant5: got no grant want grant at 0005"); end
        @(negedge clk);                 // DUT now waiting for the addr-5 response
        redirect    = 1'b1;
        redirect_pc = 16'h0040;
        @(negedge clk);
        redirect = 1'b0;
        dsz = deliv_pc.size();
        wait_deliv(dsz + 2, 40);
        idx5 = -1;
        foreach (gnt_addrs[i]) if (gnt_addrs[i] == 16'h5) idx5 = i;
        tests++;
        if (idx5 < 0 || idx5 + 1 >= gnt_addrs.size()) begin
            fails++; $display("FAIL rdw_next_addr: got no grant after 0005 want 0040");
        end else if (gnt_addrs[idx5+1] !== 16'h0040) begin
            fails++; $display("FAIL rdw_next_addr: got %h want 0040", gnt_addrs[idx5+1]);
        end
        saw5 = 0;
        foreach (deliv_pc[i]) if (deliv_pc[i] == 16'h5) saw5 = 1;
        tests++; if (saw5) begin fails++; $display("FAIL rdw_no_pc5: got pc 0005 delivered want none"); end
        tests++;
        if (deliv_pc.size() <= dsz) begin
            fails++; $display("FAIL rdw_first: got no delivery want pc 0040");
        end else begin
            if (deliv_pc[dsz] !== 16'h0040) begin fails++; $display("FAIL rdw_first: got %h want 0040", deliv_pc[dsz]); end
            tests++;
            if (deliv_word[dsz] !== 32'h0100_0040) begin fails++; $display("FAIL rdw_word: got %h want 01000040", deliv_word[dsz]); end
        end
    endtask

    task automatic test_redirect_req();
        int dsz;
        fill_mem();
        apply_reset();
        id_ready = 1'b0;
        repeat (12) @(negedge clk);     // queue full, FSM idle
        gnt_en      = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 16'h0020;
        @(negedge clk);
        redirect = 1'b0;
        tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL rdr_flush: got valid %b want 0", instr_valid); end
        tests++; if (imem_bus.imem_req !== 1'b1) begin fails++; $display("FAIL rdr_req: got %b want 1", imem_bus.imem_req); end
        tests++; if (imem_bus.imem_addr !== 16'h0020) begin fails++; $display("FAIL rdr_addr: got %h want 0020", imem_bus.imem_addr); end
        repeat (2) @(negedge clk);
        tests++; if (imem_bus.imem_addr !== 16'h0020) begin fails++; $display("FAIL rdr_addr_stable: got %h want 0020", imem_bus.imem_addr); end
        gnt_en   = 1'b1;
        id_ready = 1'b1;
        dsz = deliv_pc.size();
        wait_deliv(dsz + 1, 20);
        tests++;
        if (deliv_pc.size() <= dsz) begin
            fails++; $display("FAIL rdr_first: got no delivery want pc 0020");
        end else if (deliv_pc[dsz] !== 16'h0020) begin
            fails++; $display("FAIL rdr_first: got %h want 0020", deliv_pc[dsz]);
        end
    endtask

    task automatic test_halt();
        bit seen;
        int req_high;
        int dsz;
        fill_mem();
        mem_words[3] = 32'hD000_0000;
        apply_reset();
        seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (halted) seen = 1;
        end
        tests++; if (!seen) begin fails++; $display("FAIL halt_seen: got halted 0 want 1"); end
        req_high = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (imem_bus.imem_req) req_high++;
        end
        tests++; if (req_high != 0) begin fails++; $display("FAIL halt_no_req: got %0d req cycles want 0", req_high); end
        tests++; if (grant_cnt != 4) begin fails++; $display("FAIL halt_grants: got %0d want 4", grant_cnt); end
        tests++; if (halted !== 1'b1) begin fails++; $display("FAIL halt_hold: got %b want 1", halted); end
        tests++;
        if (deliv_pc.size() != 4) begin
            fails++; $display("FAIL halt_deliv: got %0d deliveries want 4", deliv_pc.size());
        end else begin
            tests++; if (deliv_pc[3] !== 16'h3) begin fails++; $display("FAIL halt_pc: got %h want 0003", deliv_pc[3]); end
            tests++; if (deliv_word[3] !== 32'hD000_0000) begin fails++; $display("FAIL halt_word: got %h want d0000000", deliv_word[3]); end
        end
        redirect    = 1'b1;
        redirect_pc = 16'h0000;
        @(negedge clk);
        redirect = 1'b0;
        tests++; if (halted !== 1'b0) begin fails++; $display("FAIL halt_clear: got %b want 0", halted); end
        tests++;
        if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 16'h0) begin
            fails++; $display("FAIL halt_refetch_req: got req=%b addr=%h want req=1 addr=0000", imem_bus.imem_req, imem_bus.imem_addr);
        end
        dsz = deliv_pc.size();
        wait_deliv(dsz + 1, 20);
        tests++;
        if (deliv_pc.size() <= dsz) begin
            fails++; $display("FAIL halt_refetch: got no delivery want pc 0000");
        end else if (deliv_pc[dsz] !== 16'h0) begin
            fails++; $display("FAIL halt_refetch: got %h want 0000", deliv_pc[dsz]);
        end
    endtask

    task automatic test_reset_midwait();
        bit found;
        int valid_cycles;
        fill_mem();
        apply_reset();
        lat      = 4;
        id_ready = 1'b0;
        found = 0;
        for (int k = 0; k < 60 && !found; k++) begin
            @(negedge clk);
            if (imem_bus.imem_req && imem_bus.imem_gnt && imem_bus.imem_addr == 16'h1) found = 1;
        end
        tests++; if (!found) begin fails++; $display("FAIL rst_grant1: got no grant want grant at 0001"); end
        @(negedge clk);                 // waiting for addr 1, word 0 held at the head
        #2;
        rst_n  = 1'b0;
        gnt_en = 1'b0;
        #1;
        tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL rst_async_valid: got %b want 0", instr_valid); end
        tests++; if (Instruction !== 32'h0) begin fails++; $display("FAIL rst_async_instr: got %h want 0", Instruction); end
        tests++; if (imem_bus.imem_req !== 1'b0) begin fails++; $display("FAIL rst_async_req: got %b want 0", imem_bus.imem_req); end
        @(negedge clk);
        deliv_pc.delete();
        deliv_word.delete();
        gnt_addrs.delete();
        rst_n = 1'b1;
        valid_cycles = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (instr_valid) valid_cycles++;
        end
        tests++; if (valid_cycles != 0) begin fails++; $display("FAIL rst_late_rvalid: got %0d valid cycles want 0", valid_cycles); end
        gnt_en   = 1'b1;
        id_ready = 1'b1;
        wait_deliv(2, 40);
        tests++;
        if (deliv_pc.size() < 2) begin
            fails++; $display("FAIL rst_restart: got %0d deliveries want 2", deliv_pc.size());
        end else begin
            if (deliv_pc[0] !== 16'h0) begin fails++; $display("FAIL rst_restart: got %h want 0000", deliv_pc[0]); end
            tests++;
            if (deliv_pc[1] !== 16'h1) begin fails++; $display("FAIL rst_restart_pc1: got %h want 0001", deliv_pc[1]); end
        end
    endtask

    task automatic test_branch();
        logic [15:0] exp_pc;
`ifdef PREDECODE_BRANCH_EN
        exp_pc = 16'h0004;
`else
        exp_pc = 16'h0009;
`endif
        fill_mem();
        mem_words[8] = 32'hC000_FFFC;
        apply_reset();
        wait_deliv(10, 80);
        tests++;
        if (deliv_pc.size() < 10) begin
            fails++; $display("FAIL br_count: got %0d deliveries want 10", deliv_pc.size());
        end else begin
            tests++;
            if (deliv_pc[8] !== 16'h8 || deliv_word[8] !== 32'hC000_FFFC) begin
                fails++; $display("FAIL br_word: got pc=%h instr=%h want pc=0008 instr=c000fffc", deliv_pc[8], deliv_word[8]);
            end
            tests++;
            if (deliv_pc[9] !== exp_pc) begin fails++; $display("FAIL br_next_pc: got %h want %h", deliv_pc[9], exp_pc); end
        end
    endtask

    initial begin
        fill_mem();
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_wait();
        test_redirect_req();
        test_halt();
        test_reset_midwait();
        test_branch();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
